// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC-driven instruction fetch with req/ack memory port and decode FIFO
// Optional FETCH_BYPASS_EN: zero-latency forwarding of imem_rdata when the FIFO is empty.
module instr_fetch_unit #(
  parameter int FIFO_DEPTH = 2,
  parameter int XLEN       = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc,
  input  logic            pc_load,
  input  logic            flush,
  output logic            fetch_busy,
  output logic            misalign_err,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW:0] DEPTH_C = FIFO_DEPTH[PW:0];

  typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} state_t;
  state_t state, state_next;

  logic [XLEN-1:0] addr_q, req_addr, pc_aligned;
  logic            pending;
  logic [XLEN-1:0] pc_mem   [FIFO_DEPTH];
  logic [31:0]     data_mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [PW:0]     count;
  logic            accept, has_room, empty, fifo_push, fifo_pop, bypass_hit;

  assign pc_aligned = {pc[XLEN-1:2], 2'b00};
  assign accept     = pc_load && ((state == IDLE) || flush);
  assign has_room   = count < DEPTH_C;
  assign empty      = (count == '0);
  assign imem_addr  = req_addr;

`ifdef FETCH_BYPASS_EN
  assign bypass_hit = (state == REQ) && imem_ack && !flush && empty;
`else
  assign bypass_hit = 1'b0;
`endif

  // A bypassed word consumed in the same cycle never occupies a FIFO slot.
  assign fifo_push = (state == REQ) && imem_ack && !flush && !(bypass_hit && inst_ready);
  assign fifo_pop  = !empty && inst_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (flush) begin
      case (state)
        REQ:     state_next = imem_ack ? (pc_load ? REQ : IDLE) : DRAIN;
        DRAIN:   state_next = imem_ack ? (pc_load ? REQ : IDLE) : DRAIN;
        default: state_next = pc_load ? REQ : IDLE;
      endcase
    end else begin
      case (state)
        IDLE:    if (accept) state_next = has_room ? REQ : HOLD;
        HOLD:    if (has_room) state_next = REQ;
        REQ:     if (imem_ack) state_next = IDLE;
        DRAIN:   if (imem_ack) state_next = pending ? REQ : IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    imem_req   = (state == REQ) || (state == DRAIN);
    fetch_busy = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q       <= '0;
      req_addr     <= '0;
      pending      <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= accept && (|pc[1:0]);
      if (accept) addr_q <= pc_aligned;
      // imem_addr only moves when a new request starts, so it stays stable through a drain.
      if (state_next == REQ && (state != REQ || flush))
        req_addr <= accept ? pc_aligned : addr_q;
      if (state_next == DRAIN) pending <= flush ? pc_load : pending;
      else                     pending <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
      if (fifo_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (fifo_push && !fifo_pop)      count <= count + 1'b1;
      else if (fifo_pop && !fifo_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_push) begin
      pc_mem[wr_ptr]   <= req_addr;
      data_mem[wr_ptr] <= imem_rdata;
    end
  end

  always_comb begin
    inst_valid = !empty || bypass_hit;
    inst       = '0;
    inst_pc    = '0;
    if (!empty) begin
      inst    = data_mem[rd_ptr];
      inst_pc = pc_mem[rd_ptr];
    end else if (bypass_hit) begin
      inst    = imem_rdata;
      inst_pc = req_addr;
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc;
  logic        pc_load, flush, imem_ack, inst_ready;
  logic [31:0] imem_rdata;
  logic        fetch_busy, misalign_err, imem_req, inst_valid;
  logic [31:0] imem_addr, inst, inst_pc;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.FIFO_DEPTH(2), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .pc_load(pc_load), .flush(flush),
    .fetch_busy(fetch_busy), .misalign_err(misalign_err), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a load, let it request next cycle, ack immediately with the given word.
  task automatic fetch(input logic [31:0] a, input logic [31:0] d);
    pc = a; pc_load = 1'b1;
    step();
    pc_load = 1'b0; imem_ack = 1'b1; imem_rdata = d;
    step();
    imem_ack = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; pc = '0; pc_load = 0; flush = 0; imem_ack = 0; inst_ready = 0; imem_rdata = '0;
    #3;
    check("rst_req", imem_req, 0);
    check("rst_busy", fetch_busy, 0);
    check("rst_valid", inst_valid, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_inst", inst, 0);
    step();
    rst_n = 1'b1;
    step();

    // basic fetch, ack three cycles after request
    pc = 32'h100; pc_load = 1'b1;
    step();
    pc_load = 1'b0;
    check("t2_req", imem_req, 1);
    check("t2_addr", imem_addr, 32'h100);
    check("t2_busy", fetch_busy, 1);
    check("t2_mis", misalign_err, 0);
    step(); step();
    check("t2_req_held", imem_req, 1);
    imem_ack = 1'b1; imem_rdata = 32'h0050_0093;
    #1;
`ifdef FETCH_BYPASS_EN
    check("t2_valid_ack", inst_valid, 1);
`else
    check("t2_valid_ack", inst_valid, 0);
`endif
    step();
    imem_ack = 1'b0;
    check("t2_valid", inst_valid, 1);
    check("t2_inst", inst, 32'h0050_0093);
    check("t2_pc", inst_pc, 32'h100);
    check("t2_idle", fetch_busy, 0);
    check("t2_req_drop", imem_req, 0);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    check("t2_pop_valid", inst_valid, 0);
    check("t2_pop_inst", inst, 0);

    // fill the FIFO, third load must wait in HOLD
    fetch(32'h0, 32'hA1);
    fetch(32'h4, 32'hA2);
    pc = 32'h8; pc_load = 1'b1;
    step();
    pc_load = 1'b0;
    check("t3_hold_busy", fetch_busy, 1);
    check("t3_hold_req", imem_req, 0);
    check("t3_head", inst, 32'hA1);
    check("t3_head_pc", inst_pc, 32'h0);
    step();
    check("t3_hold_req2", imem_req, 0);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    check("t3_head2_pc", inst_pc, 32'h4);
    step();
    check("t3_req", imem_req, 1);
    check("t3_req_addr", imem_addr, 32'h8);
    imem_ack = 1'b1; imem_rdata = 32'hA3;
    step();
    imem_ack = 1'b0;
    inst_ready = 1'b1;
    check("t3_d2", inst, 32'hA2);
    step();
    check("t3_d3", inst, 32'hA3);
    check("t3_d3_pc", inst_pc, 32'h8);
    step();
    inst_ready = 1'b0;
    check("t3_empty", inst_valid, 0);

    // redirect during an outstanding request
    fetch(32'h100, 32'h11);
    pc = 32'h104; pc_load = 1'b1;
    step();
    pc_load = 1'b0;
    check("t4_req", imem_addr, 32'h104);
    pc = 32'h200; pc_load = 1'b1; flush = 1'b1;
    step();
    pc_load = 1'b0; flush = 1'b0;
    check("t4_flushed", inst_valid, 0);
    check("t4_drain_req", imem_req, 1);
    check("t4_drain_addr", imem_addr, 32'h104);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    #1;
    check("t4_drain_valid", inst_valid, 0);
    step();
    imem_ack = 1'b0;
    check("t4_discard", inst_valid, 0);
    check("t4_new_req", imem_req, 1);
    check("t4_new_addr", imem_addr, 32'h200);
    imem_ack = 1'b1; imem_rdata = 32'h13;
    step();
    imem_ack = 1'b0;
    check("t4_inst", inst, 32'h13);
    check("t4_pc", inst_pc, 32'h200);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    check("t4_empty", inst_valid, 0);

    // misaligned pc and ignored load while busy
    pc = 32'h102; pc_load = 1'b1;
    step();
    check("t5_addr", imem_addr, 32'h100);
    check("t5_mis", misalign_err, 1);
    pc = 32'h300;
    step();
    pc_load = 1'b0;
    check("t5_mis_pulse", misalign_err, 0);
    check("t5_addr_stable", imem_addr, 32'h100);
    imem_ack = 1'b1; imem_rdata = 32'h22;
    step();
    imem_ack = 1'b0;
    check("t5_inst_pc", inst_pc, 32'h100);
    check("t5_idle", fetch_busy, 0);
    step();
    check("t5_no_req", imem_req, 0);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;

    // ack with FIFO empty and decode ready
    pc = 32'h500; pc_load = 1'b1;
    step();
    pc_load = 1'b0; inst_ready = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h77;
    #1;
`ifdef FETCH_BYPASS_EN
    check("t6_byp_valid", inst_valid, 1);
    check("t6_byp_inst", inst, 32'h77);
    check("t6_byp_pc", inst_pc, 32'h500);
    step();
    imem_ack = 1'b0; inst_ready = 1'b0;
    check("t6_count0", inst_valid, 0);
`else
    check("t6_valid", inst_valid, 0);
    step();
    imem_ack = 1'b0;
    check("t6_valid_next", inst_valid, 1);
    check("t6_inst", inst, 32'h77);
    step();
    inst_ready = 1'b0;
    check("t6_empty", inst_valid, 0);
`endif

    // asynchronous reset while a request is outstanding
    pc = 32'h40; pc_load = 1'b1;
    step();
    pc_load = 1'b0;
    check("t1_req", imem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t1_req_rst", imem_req, 0);
    check("t1_busy_rst", fetch_busy, 0);
    check("t1_valid_rst", inst_valid, 0);
    step();
    rst_n = 1'b1;
    step();
    check("t1_after", imem_req, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
